// File: rtl/udp_rx_sample_unpack.sv
// udp_rx_sample_unpack
//
// Purpose: sits downstream of the UDP RX interface. It accepts datagrams addressed to
// LISTEN_PORT and packs their big-endian byte pairs into 16-bit samples on an AXI-Stream
// master. All other datagrams are drained and discarded. The block also keeps per-packet
// source metadata and saturating statistics.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   udp_rx_hdr_*                 UDP header handshake (valid/ready, src_ip, src_port, dest_port)
//   udp_rx_t*                    8-bit payload AXI-Stream slave
//   m_sample_t*                  16-bit sample AXI-Stream master, first byte in [15:8]
//   m_pkt_src_ip/port            source of the datagram most recently accepted at the header
//   stat_*                       saturating 16-bit event counters
//
// Build option: define UDP_UNPACK_SRC_FILTER_EN to additionally require
// udp_rx_src_ip == ALLOWED_SRC_IP for acceptance. When it is undefined, ALLOWED_SRC_IP is unused.
module udp_rx_sample_unpack #(
    parameter logic [15:0] LISTEN_PORT    = 16'd5005,
    parameter int unsigned MAX_SAMPLES    = 256,
    parameter logic [31:0] ALLOWED_SRC_IP = 32'hC0A8_0164
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_rx_hdr_valid,
    output logic        udp_rx_hdr_ready,
    input  logic [31:0] udp_rx_src_ip,
    input  logic [15:0] udp_rx_src_port,
    input  logic [15:0] udp_rx_dest_port,
    input  logic [7:0]  udp_rx_tdata,
    input  logic        udp_rx_tvalid,
    output logic        udp_rx_tready,
    input  logic        udp_rx_tlast,
    output logic [15:0] m_sample_tdata,
    output logic        m_sample_tvalid,
    input  logic        m_sample_tready,
    output logic        m_sample_tlast,
    output logic [31:0] m_pkt_src_ip,
    output logic [15:0] m_pkt_src_port,
    output logic [15:0] stat_pkt_accepted,
    output logic [15:0] stat_pkt_dropped,
    output logic [15:0] stat_odd_len,
    output logic [15:0] stat_truncated
);

    localparam int unsigned     CntW    = $clog2(MAX_SAMPLES) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_SAMPLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHi   = 2'd1;
    localparam logic [1:0] StLo   = 2'd2;
    localparam logic [1:0] StDrop = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [7:0]      byte_hi_q, byte_hi_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [31:0]     src_ip_q, src_ip_d;
    logic [15:0]     src_port_q, src_port_d;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     drop_q, drop_d;
    logic [15:0]     odd_q, odd_d;
    logic [15:0]     trunc_q, trunc_d;

    logic rx_tready;
    logic hdr_ok;
    logic in_fire;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef UDP_UNPACK_SRC_FILTER_EN
    assign hdr_ok = (udp_rx_dest_port == LISTEN_PORT) && (udp_rx_src_ip == ALLOWED_SRC_IP);
`else
    assign hdr_ok = (udp_rx_dest_port == LISTEN_PORT);
    logic unused_allowed_ip;
    assign unused_allowed_ip = ^ALLOWED_SRC_IP;
`endif

    // Payload is only stalled while a sample sits unconsumed in the output register.
    always_comb begin
        case (state_q)
            StHi, StLo: rx_tready = ~out_valid_q | m_sample_tready;
            StDrop:     rx_tready = 1'b1;
            default:    rx_tready = 1'b0;
        endcase
    end

    assign in_fire = udp_rx_tvalid & rx_tready;

    always_comb begin
        state_d     = state_q;
        byte_hi_d   = byte_hi_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        src_ip_d    = src_ip_q;
        src_port_d  = src_port_q;
        acc_d       = acc_q;
        drop_d      = drop_q;
        odd_d       = odd_q;
        trunc_d     = trunc_q;

        if (out_valid_q && m_sample_tready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (udp_rx_hdr_valid) begin
                    src_ip_d   = udp_rx_src_ip;
                    src_port_d = udp_rx_src_port;
                    if (hdr_ok) begin
                        state_d = StHi;
                        acc_d   = sat_inc(acc_q);
                        count_d = '0;
                    end else begin
                        state_d = StDrop;
                        drop_d  = sat_inc(drop_q);
                    end
                end
            end
            StHi: begin
                if (in_fire) begin
                    byte_hi_d = udp_rx_tdata;
                    if (udp_rx_tlast) begin
                        // Odd (or single-byte) payload: pad the lone byte into a final sample.
                        out_data_d  = {udp_rx_tdata, 8'h00};
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b1;
                        odd_d       = sat_inc(odd_q);
                        state_d     = StIdle;
                    end else begin
                        state_d = StLo;
                    end
                end
            end
            StLo: begin
                if (in_fire) begin
                    out_data_d  = {byte_hi_q, udp_rx_tdata};
                    out_valid_d = 1'b1;
                    out_last_d  = udp_rx_tlast | (count_q == LastCnt);
                    count_d     = count_q + 1'b1;
                    if (udp_rx_tlast) begin
                        state_d = StIdle;
                    end else if (count_q == LastCnt) begin
                        trunc_d = sat_inc(trunc_q);
                        state_d = StDrop;
                    end else begin
                        state_d = StHi;
                    end
                end
            end
            StDrop: begin
                if (in_fire && udp_rx_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_hi_q   <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            src_ip_q    <= '0;
            src_port_q  <= '0;
            acc_q       <= '0;
            drop_q      <= '0;
            odd_q       <= '0;
            trunc_q     <= '0;
        end else begin
            state_q     <= state_d;
            byte_hi_q   <= byte_hi_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            src_ip_q    <= src_ip_d;
            src_port_q  <= src_port_d;
            acc_q       <= acc_d;
            drop_q      <= drop_d;
            odd_q       <= odd_d;
            trunc_q     <= trunc_d;
        end
    end

    assign udp_rx_hdr_ready  = (state_q == StIdle);
    assign udp_rx_tready     = rx_tready;
    assign m_sample_tdata    = out_data_q;
    assign m_sample_tvalid   = out_valid_q;
    assign m_sample_tlast    = out_last_q;
    assign m_pkt_src_ip      = src_ip_q;
    assign m_pkt_src_port    = src_port_q;
    assign stat_pkt_accepted = acc_q;
    assign stat_pkt_dropped  = drop_q;
    assign stat_odd_len      = odd_q;
    assign stat_truncated    = trunc_q;

endmodule

// File: tb/tb_udp_rx_sample_unpack.sv
// Testbench for udp_rx_sample_unpack. The DUT is built with MAX_SAMPLES=4 so that
// truncation is reachable with short payloads. Expected samples and statistics come from
// a per-datagram reference model working on whole payload arrays.
`timescale 1ns/1ps
module tb_udp_rx_sample_unpack;

    localparam logic [15:0] Port    = 16'd5005;
    localparam int          MaxS    = 4;
    localparam logic [31:0] AllowIp = 32'hC0A8_0164;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } samp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        udp_rx_hdr_valid = 1'b0;
    logic        udp_rx_hdr_ready;
    logic [31:0] udp_rx_src_ip = '0;
    logic [15:0] udp_rx_src_port = '0;
    logic [15:0] udp_rx_dest_port = '0;
    logic [7:0]  udp_rx_tdata = '0;
    logic        udp_rx_tvalid = 1'b0;
    logic        udp_rx_tready;
    logic        udp_rx_tlast = 1'b0;
    logic [15:0] m_sample_tdata;
    logic        m_sample_tvalid;
    logic        m_sample_tready = 1'b1;
    logic        m_sample_tlast;
    logic [31:0] m_pkt_src_ip;
    logic [15:0] m_pkt_src_port;
    logic [15:0] stat_pkt_accepted;
    logic [15:0] stat_pkt_dropped;
    logic [15:0] stat_odd_len;
    logic [15:0] stat_truncated;

    udp_rx_sample_unpack #(
        .LISTEN_PORT   (Port),
        .MAX_SAMPLES   (MaxS),
        .ALLOWED_SRC_IP(AllowIp)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .udp_rx_hdr_valid (udp_rx_hdr_valid),
        .udp_rx_hdr_ready (udp_rx_hdr_ready),
        .udp_rx_src_ip    (udp_rx_src_ip),
        .udp_rx_src_port  (udp_rx_src_port),
        .udp_rx_dest_port (udp_rx_dest_port),
        .udp_rx_tdata     (udp_rx_tdata),
        .udp_rx_tvalid    (udp_rx_tvalid),
        .udp_rx_tready    (udp_rx_tready),
        .udp_rx_tlast     (udp_rx_tlast),
        .m_sample_tdata   (m_sample_tdata),
        .m_sample_tvalid  (m_sample_tvalid),
        .m_sample_tready  (m_sample_tready),
        .m_sample_tlast   (m_sample_tlast),
        .m_pkt_src_ip     (m_pkt_src_ip),
        .m_pkt_src_port   (m_pkt_src_port),
        .stat_pkt_accepted(stat_pkt_accepted),
        .stat_pkt_dropped (stat_pkt_dropped),
        .stat_odd_len     (stat_odd_len),
        .stat_truncated   (stat_truncated)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    int    errors = 0;
    int    checks = 0;
    int    m_acc = 0, m_drop = 0, m_odd = 0, m_trunc = 0;
    samp_t obs_q[$];
    samp_t exp_q[$];
    samp_t stall_log[$];
    logic [7:0] pl[$];
    int    ready_mode = 0;
    bit    stall_arm = 0;
    int    stall_left = 0;
    bit    stall_on = 0;
    bit    stall_tready_seen = 0;
    bit    saw_valid = 0;
    logic  tready_s, hdr_ready_s;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // One clock: sample everything on the falling edge, update downstream ready after rise.
    task automatic tick();
        @(negedge clk);
        tready_s    = udp_rx_tready;
        hdr_ready_s = udp_rx_hdr_ready;
        if (!rst && m_sample_tvalid) saw_valid = 1;
        if (!rst && m_sample_tvalid && m_sample_tready)
            obs_q.push_back({m_sample_tdata, m_sample_tlast});
        if (stall_on) begin
            stall_log.push_back({m_sample_tdata, m_sample_tlast});
            if (udp_rx_tready) stall_tready_seen = 1;
        end
        @(posedge clk);
        #1;
        if (stall_arm && m_sample_tvalid) begin
            stall_arm  = 0;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            m_sample_tready = 1'b0;
            stall_on        = 1;
            stall_left--;
        end else begin
            stall_on        = 0;
            m_sample_tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send_hdr(input logic [15:0] dest, input logic [31:0] ip,
                            input logic [15:0] sport, output int waits);
        udp_rx_hdr_valid = 1'b1;
        udp_rx_dest_port = dest;
        udp_rx_src_ip    = ip;
        udp_rx_src_port  = sport;
        waits = 0;
        tick();
        while (!hdr_ready_s && waits < 200) begin
            waits++;
            tick();
        end
        udp_rx_hdr_valid = 1'b0;
        if (!hdr_ready_s) begin
            checks++;
            errors++;
            $display("FAIL hdr_timeout got=no_accept exp=accept");
        end
    endtask

    task automatic send_payload(input bit with_last, input bit gaps, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < pl.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            udp_rx_tvalid = 1'b1;
            udp_rx_tdata  = pl[i];
            udp_rx_tlast  = with_last && (i == pl.size() - 1);
            tick();
            w = 0;
            while (!tready_s && w < 200) begin
                stalls++;
                w++;
                tick();
            end
            if (!tready_s) begin
                checks++;
                errors++;
                $display("FAIL payload_timeout got=stuck exp=tready");
                break;
            end
            udp_rx_tvalid = 1'b0;
        end
        udp_rx_tvalid = 1'b0;
        udp_rx_tlast  = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < 400 && obs_q.size() < n; k++) tick();
        repeat (4) tick();
    endtask

    // Reference model of one complete datagram whose payload is in pl.
    task automatic model(input logic [15:0] dest, input logic [31:0] ip);
        bit ok;
        int n, ns;
        logic [7:0] lo;
        ok = (dest == Port);
`ifdef UDP_UNPACK_SRC_FILTER_EN
        ok = ok && (ip == AllowIp);
`else
        if (ip == 32'h0) ok = ok;
`endif
        if (!ok) begin
            m_drop++;
            return;
        end
        m_acc++;
        n = pl.size();
        if (n > 2 * MaxS) begin
            m_trunc++;
            ns = MaxS;
        end else begin
            ns = (n + 1) / 2;
            if (n % 2 == 1) m_odd++;
        end
        for (int i = 0; i < ns; i++) begin
            lo = (2 * i + 1 < n) ? pl[2 * i + 1] : 8'h00;
            exp_q.push_back({pl[2 * i], lo, (i == ns - 1)});
        end
    endtask

    task automatic test_reset();
        checks++; if (udp_rx_hdr_ready !== 1'b1) begin errors++;
            $display("FAIL reset_hdr_ready got=%b exp=1", udp_rx_hdr_ready); end
        checks++; if (udp_rx_tready !== 1'b0) begin errors++;
            $display("FAIL reset_tready got=%b exp=0", udp_rx_tready); end
        checks++; if ({m_sample_tvalid, m_sample_tlast, m_sample_tdata} !== 18'h0) begin errors++;
            $display("FAIL reset_sample got=%b/%b/%h exp=0", m_sample_tvalid, m_sample_tlast,
                     m_sample_tdata); end
        checks++; if ({m_pkt_src_ip, m_pkt_src_port} !== 48'h0) begin errors++;
            $display("FAIL reset_pkt got=%h/%h exp=0", m_pkt_src_ip, m_pkt_src_port); end
        checks++; if ({stat_pkt_accepted, stat_pkt_dropped, stat_odd_len, stat_truncated} !== 64'h0)
            begin errors++; $display("FAIL reset_stats got=%h/%h/%h/%h exp=0", stat_pkt_accepted,
                                     stat_pkt_dropped, stat_odd_len, stat_truncated); end
    endtask

    task automatic test_basic();
        int w, st;
        obs_q.delete(); exp_q.delete();
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_hdr(Port, AllowIp, 16'd1234, w);
        checks++; if (m_pkt_src_ip !== AllowIp || m_pkt_src_port !== 16'd1234) begin errors++;
            $display("FAIL basic_pkt got=%h/%0d exp=%h/1234", m_pkt_src_ip, m_pkt_src_port,
                     AllowIp); end
        send_payload(1, 0, st);
        model(Port, AllowIp);
        drain(exp_q.size());
        checks++; if (st != 0) begin errors++; $display("FAIL basic_stalls got=%0d exp=0", st); end
        checks++; if (obs_q.size() != 2) begin errors++;
            $display("FAIL basic_count got=%0d exp=2", obs_q.size()); end
        checks++; if (obs_q.size() > 0 && obs_q[0] !== samp_t'({16'h0102, 1'b0})) begin errors++;
            $display("FAIL basic_s0 got=%h/%b exp=0102/0", obs_q[0].d, obs_q[0].l); end
        checks++; if (obs_q.size() > 1 && obs_q[1] !== samp_t'({16'h0304, 1'b1})) begin errors++;
            $display("FAIL basic_s1 got=%h/%b exp=0304/1", obs_q[1].d, obs_q[1].l); end
        checks++; if (stat_pkt_accepted !== sat16(m_acc)) begin errors++;
            $display("FAIL basic_acc got=%0d exp=%0d", stat_pkt_accepted, m_acc); end
    endtask

    task automatic test_port_filter();
        int w, st;
        obs_q.delete(); exp_q.delete();
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'h10 + i));
        saw_valid = 0;
        send_hdr(16'd5006, 32'h0A00_0001, 16'd99, w);
        send_payload(1, 0, st);
        model(16'd5006, 32'h0A00_0001);
        checks++; if (st != 0) begin errors++; $display("FAIL drop_stalls got=%0d exp=0", st); end
        checks++; if (saw_valid) begin errors++; $display("FAIL drop_valid got=1 exp=0"); end
        checks++; if (stat_pkt_dropped !== sat16(m_drop)) begin errors++;
            $display("FAIL drop_count got=%0d exp=%0d", stat_pkt_dropped, m_drop); end
        checks++; if (m_pkt_src_port !== 16'd99) begin errors++;
            $display("FAIL drop_pkt_port got=%0d exp=99", m_pkt_src_port); end
        send_hdr(Port, AllowIp, 16'd7, w);
        checks++; if (w != 0) begin errors++; $display("FAIL drop_next_hdr got=%0d exp=0", w); end
        pl = '{8'h55, 8'h66};
        send_payload(1, 0, st);
        model(Port, AllowIp);
        drain(exp_q.size());
        checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++;
            $display("FAIL drop_next_data got=%0d samples exp=1 of 5566/1", obs_q.size()); end
    endtask

    task automatic test_odd_len();
        int w, st;
        obs_q.delete(); exp_q.delete();
        pl = '{8'hAA, 8'hBB, 8'hCC};
        send_hdr(Port, AllowIp, 16'd1, w);
        send_payload(1, 0, st);
        model(Port, AllowIp);
        pl = '{8'h5A};
        send_hdr(Port, AllowIp, 16'd2, w);
        send_payload(1, 0, st);
        model(Port, AllowIp);
        drain(exp_q.size());
        checks++; if (obs_q.size() != 3) begin errors++;
            $display("FAIL odd_count got=%0d exp=3", obs_q.size()); end
        checks++; if (obs_q.size() > 1 && obs_q[1] !== samp_t'({16'hCC00, 1'b1})) begin errors++;
            $display("FAIL odd_pad got=%h/%b exp=CC00/1", obs_q[1].d, obs_q[1].l); end
        checks++; if (obs_q.size() > 2 && obs_q[2] !== samp_t'({16'h5A00, 1'b1})) begin errors++;
            $display("FAIL odd_single got=%h/%b exp=5A00/1", obs_q[2].d, obs_q[2].l); end
        checks++; if (stat_odd_len !== sat16(m_odd)) begin errors++;
            $display("FAIL odd_stat got=%0d exp=%0d", stat_odd_len, m_odd); end
    endtask

    task automatic test_backpressure();
        int w, st;
        obs_q.delete(); exp_q.delete(); stall_log.delete();
        stall_tready_seen = 0;
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        stall_arm = 1;
        send_hdr(Port, AllowIp, 16'd3, w);
        send_payload(1, 0, st);
        model(Port, AllowIp);
        drain(exp_q.size());
        checks++; if (stall_log.size() != 5) begin errors++;
            $display("FAIL bp_stall_len got=%0d exp=5", stall_log.size()); end
        foreach (stall_log[i]) begin
            checks++; if (stall_log[i] !== exp_q[0]) begin errors++;
                $display("FAIL bp_hold[%0d] got=%h exp=%h", i, stall_log[i].d, exp_q[0].d); end
        end
        checks++; if (stall_tready_seen) begin errors++;
            $display("FAIL bp_tready got=1 exp=0"); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL bp_s%0d got=%h/%b exp=%h/%b", i, obs_q[i].d, obs_q[i].l,
                         exp_q[i].d, exp_q[i].l); end
        end
    endtask

    task automatic test_truncation();
        int w, st;
        obs_q.delete(); exp_q.delete();
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'(8'hA0 + i));
        send_hdr(Port, AllowIp, 16'd4, w);
        send_payload(1, 0, st);
        model(Port, AllowIp);
        drain(exp_q.size());
        checks++; if (st != 0) begin errors++; $display("FAIL trunc_stalls got=%0d exp=0", st); end
        checks++; if (obs_q.size() != MaxS) begin errors++;
            $display("FAIL trunc_count got=%0d exp=%0d", obs_q.size(), MaxS); end
        checks++; if (obs_q.size() == MaxS && obs_q[MaxS-1] !== samp_t'({16'hA6A7, 1'b1}))
            begin errors++; $display("FAIL trunc_last got=%h/%b exp=A6A7/1", obs_q[MaxS-1].d,
                                     obs_q[MaxS-1].l); end
        checks++; if (stat_truncated !== sat16(m_trunc)) begin errors++;
            $display("FAIL trunc_stat got=%0d exp=%0d", stat_truncated, m_trunc); end
        checks++; if (udp_rx_hdr_ready !== 1'b1) begin errors++;
            $display("FAIL trunc_idle got=%b exp=1", udp_rx_hdr_ready); end
    endtask

    task automatic test_src_filter();
        int w, st;
        obs_q.delete(); exp_q.delete();
        pl = '{8'h11, 8'h22};
        send_hdr(Port, AllowIp, 16'd5, w);
        send_payload(1, 0, st);
        model(Port, AllowIp);
        pl = '{8'h33, 8'h44};
        send_hdr(Port, AllowIp + 32'd1, 16'd6, w);
        send_payload(1, 0, st);
        model(Port, AllowIp + 32'd1);
        drain(exp_q.size());
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL src_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        checks++; if (stat_pkt_accepted !== sat16(m_acc) || stat_pkt_dropped !== sat16(m_drop))
            begin errors++; $display("FAIL src_stats got=%0d/%0d exp=%0d/%0d", stat_pkt_accepted,
                                     stat_pkt_dropped, m_acc, m_drop); end
    endtask

    task automatic test_back_to_back();
        int w, st, wsum, ssum;
        obs_q.delete(); exp_q.delete();
        wsum = 0; ssum = 0;
        for (int k = 0; k < 3; k++) begin
            pl.delete();
            for (int i = 0; i < 4 + 2 * k; i++) pl.push_back(8'($urandom));
            send_hdr(Port, AllowIp, 16'(k), w);
            if (k > 0) wsum += w;
            send_payload(1, 0, st);
            ssum += st;
            model(Port, AllowIp);
        end
        drain(exp_q.size());
        checks++; if (wsum != 0) begin errors++; $display("FAIL b2b_hdr_wait got=%0d exp=0", wsum); end
        checks++; if (ssum != 0) begin errors++; $display("FAIL b2b_stalls got=%0d exp=0", ssum); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL b2b_s%0d got=%h/%b exp=%h/%b", i, obs_q[i].d, obs_q[i].l,
                         exp_q[i].d, exp_q[i].l); end
        end
    endtask

    task automatic test_reset_midpacket();
        int w, st;
        pl = '{8'hDE, 8'hAD, 8'hBE};
        send_hdr(Port, AllowIp, 16'd8, w);
        send_payload(0, 0, st);
        rst = 1'b1;
        tick();
        checks++; if (m_sample_tvalid !== 1'b0 || udp_rx_hdr_ready !== 1'b1 || udp_rx_tready !== 1'b0)
            begin errors++; $display("FAIL rstmid_ctl got=%b/%b/%b exp=0/1/0", m_sample_tvalid,
                                     udp_rx_hdr_ready, udp_rx_tready); end
        checks++; if ({stat_pkt_accepted, stat_pkt_dropped, stat_odd_len, stat_truncated} !== 64'h0)
            begin errors++; $display("FAIL rstmid_stats got=%h exp=0", stat_pkt_accepted); end
        rst = 1'b0;
        m_acc = 0; m_drop = 0; m_odd = 0; m_trunc = 0;
        obs_q.delete(); exp_q.delete();
        pl = '{8'h12, 8'h34};
        send_hdr(Port, AllowIp, 16'd9, w);
        send_payload(1, 0, st);
        model(Port, AllowIp);
        drain(exp_q.size());
        checks++; if (obs_q.size() != 1 || obs_q[0] !== samp_t'({16'h1234, 1'b1})) begin errors++;
            $display("FAIL rstmid_after got=%0d samples exp=1 of 1234/1", obs_q.size()); end
    endtask

    task automatic test_random();
        int w, st, n;
        logic [15:0] dest, sport;
        logic [31:0] ip;
        obs_q.delete(); exp_q.delete();
        ready_mode = 1;
        for (int k = 0; k < 25; k++) begin
            dest  = ($urandom_range(0, 2) == 0) ? 16'(16'd5006 + $urandom_range(0, 50)) : Port;
            ip    = ($urandom_range(0, 3) == 0) ? AllowIp + 32'd1 : AllowIp;
            sport = 16'($urandom);
            n     = $urandom_range(1, 11);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            send_hdr(dest, ip, sport, w);
            checks++; if (m_pkt_src_ip !== ip || m_pkt_src_port !== sport) begin errors++;
                $display("FAIL rnd_pkt%0d got=%h/%h exp=%h/%h", k, m_pkt_src_ip, m_pkt_src_port,
                         ip, sport); end
            send_payload(1, 1, st);
            model(dest, ip);
        end
        drain(exp_q.size());
        ready_mode = 0;
        checks++; if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL rnd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
                $display("FAIL rnd_s%0d got=%h/%b exp=%h/%b", i, obs_q[i].d, obs_q[i].l,
                         exp_q[i].d, exp_q[i].l); end
        end
        checks++; if (stat_pkt_accepted !== sat16(m_acc) || stat_pkt_dropped !== sat16(m_drop) ||
                      stat_odd_len !== sat16(m_odd) || stat_truncated !== sat16(m_trunc)) begin
            errors++;
            $display("FAIL rnd_stats got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", stat_pkt_accepted,
                     stat_pkt_dropped, stat_odd_len, stat_truncated, m_acc, m_drop, m_odd, m_trunc);
        end
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_port_filter();
        test_odd_len();
        test_backpressure();
        test_truncation();
        test_src_filter();
        test_back_to_back();
        test_reset_midpacket();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
